// File: rtl/io_lut_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_lut_filter_pkg
// Brief    : Shared helpers for io_lut_filter; reset polarity follows the
//            optional IO_LUT_FILTER_PULLUP_EN build macro.
// Revision : 1.0 - initial release
// ============================================================================
package io_lut_filter_pkg;

   localparam int EVT_W_DEFAULT = 16;

`ifdef IO_LUT_FILTER_PULLUP_EN
   localparam logic PULLUP_RESET = 1'b1;
`else
   localparam logic PULLUP_RESET = 1'b0;
`endif

   function automatic int deb_cnt_width(input int cycles);
      return (cycles < 1) ? 1 : $clog2(cycles + 1);
   endfunction

   // AND truth table: only the all-ones input vector yields 1 (NUM_IN <= 6).
   function automatic logic [63:0] and_truth_table(input int num_in);
      return 64'(1) << ((1 << num_in) - 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/io_debounce_chan.sv
`default_nettype none
// ============================================================================
// Module   : io_debounce_chan
// Brief    : One pad channel: multi-flop synchroniser followed by a
//            consecutive-difference debounce filter.
// Revision : 1.0 - initial release
// ============================================================================
module io_debounce_chan
   import io_lut_filter_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_pad,
   output logic o_deb
);

   localparam int                c_CNT_W    = deb_cnt_width(DEBOUNCE_CYCLES);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [c_CNT_W-1:0]     r_cnt;
   logic                   r_deb;
   logic                   w_sync;

   assign w_sync = r_sync[SYNC_STAGES-1];
   assign o_deb  = r_deb;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= {SYNC_STAGES{PULLUP_RESET}};
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad};
      end
   end

   // Any return to equality restarts the count, so short glitches never land.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_deb <= PULLUP_RESET;
         r_cnt <= '0;
      end else if (w_sync == r_deb) begin
         r_cnt <= '0;
      end else if (r_cnt == c_CNT_LAST) begin
         r_deb <= w_sync;
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/io_lut_filter.sv
`default_nettype none
// ============================================================================
// Module   : io_lut_filter
// Brief    : N-channel debounced pad inputs feeding a registered truth table,
//            with change pulse and saturating rising-edge counter.
//            Build macro IO_LUT_FILTER_PULLUP_EN: all-ones channel reset.
// Revision : 1.0 - initial release
// ============================================================================
module io_lut_filter
   import io_lut_filter_pkg::*;
#(
   parameter int                        NUM_IN          = 2,
   parameter int                        SYNC_STAGES     = 2,
   parameter int                        DEBOUNCE_CYCLES = 4,
   parameter logic [(1<<NUM_IN)-1:0]    LUT_INIT        = (1 << NUM_IN)'(and_truth_table(NUM_IN)),
   parameter int                        EVT_W           = EVT_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_IN-1:0] pad_in,
   output logic [NUM_IN-1:0] deb_out,
   output logic              lut_out,
   output logic              out_chg,
   output logic [EVT_W-1:0]  evt_cnt,
   output logic              evt_sat
);

   localparam logic [NUM_IN-1:0] c_DEB_RST = {NUM_IN{PULLUP_RESET}};
   localparam logic              c_LUT_RST = LUT_INIT[c_DEB_RST];
   localparam logic [EVT_W-1:0]  c_EVT_MAX = '1;

   logic [NUM_IN-1:0] w_deb;
   logic              w_lut_next;
   logic              w_rise;
   logic              r_lut;
   logic              r_chg;
   logic [EVT_W-1:0]  r_evt;
   logic              r_sat;

   generate
      for (genvar k = 0; k < NUM_IN; k++) begin : g_chan
         io_debounce_chan #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .i_pad (pad_in[k]),
            .o_deb (w_deb[k])
         );
      end
   endgenerate

   assign w_lut_next = LUT_INIT[w_deb];
   assign w_rise     = w_lut_next & ~r_lut;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lut <= c_LUT_RST;
         r_chg <= 1'b0;
      end else begin
         r_lut <= w_lut_next;
         r_chg <= w_lut_next ^ r_lut;
      end
   end

   // Saturation flag rises together with the final increment and is sticky.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_evt <= '0;
         r_sat <= 1'b0;
      end else if (w_rise && (r_evt != c_EVT_MAX)) begin
         r_evt <= r_evt + 1'b1;
         if (r_evt == (c_EVT_MAX - 1'b1)) begin
            r_sat <= 1'b1;
         end
      end
   end

   assign deb_out = w_deb;
   assign lut_out = r_lut;
   assign out_chg = r_chg;
   assign evt_cnt = r_evt;
   assign evt_sat = r_sat;

endmodule
`default_nettype wire

// File: doc/io_lut_filter.md
Name: io_lut_filter

Overview:
- N-channel pad-input conditioning block for fasm2bels round-trip test designs.
- Successor to the flat IBUF -> LUT6_2 -> OBUF pattern.
- Per channel: synchroniser, then debounce filter. The NUM_IN debounced bits index a parametrised truth table. The result is registered and drives one output pad.
- Adds an output-change pulse and a saturating rising-edge event counter, so the bench can observe edges.

Parameters:
- NUM_IN, 2, number of pad input channels (1..6, the LUT6 input limit).
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised value must differ before it is accepted (>=1).
- LUT_INIT, all-ones only at index 2^NUM_IN-1 (AND), truth table of width 2^NUM_IN. Bit i is the output for debounced vector == i.
- EVT_W, 16, event counter width.

Ports:
- clk  input  1  single clock.
- rst_n  input  1  asynchronous assert, active-low reset.
- pad_in  input  NUM_IN  raw asynchronous pad inputs; bit k is channel k.
- deb_out  output  NUM_IN  debounced channel values.
- lut_out  output  1  registered LUT_INIT[deb_out]; drives the output pad.
- out_chg  output  1  one-cycle pulse when lut_out changed on this edge.
- evt_cnt  output  EVT_W  count of lut_out 0->1 transitions; saturates.
- evt_sat  output  1  high once evt_cnt reaches all-ones.

Behaviour:
- Reset: rst_n low clears the following asynchronously, to 0 by default (see Optional Feature):
  - all sync flops and deb_out;
  - all debounce counters;
  - lut_out, out_chg, evt_cnt and evt_sat.
  - lut_out resets to LUT_INIT[reset deb value] registered form, i.e. LUT_INIT[0] by default.
- Synchroniser: sync[k] = pad_in[k] delayed SYNC_STAGES clk edges. No reset-release gating beyond the async clear.
- Debounce per channel, counter width $clog2(DEBOUNCE_CYCLES+1):
  - sync == deb: counter <= 0.
  - sync != deb and counter == DEBOUNCE_CYCLES-1: deb <= sync, counter <= 0.
  - otherwise: counter <= counter+1.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles is fully rejected. Any return to equality restarts the count.
  - DEBOUNCE_CYCLES=1 degenerates to a single register.
- LUT stage: lut_out <= LUT_INIT[deb_out], one cycle after deb_out changes.
- out_chg <= (next lut_out != lut_out). It is asserted in the same cycle the new lut_out is visible.
- Event counter:
  - On each lut_out 0->1 transition, evt_cnt increments unless already all-ones. At all-ones it holds and evt_sat stays high until reset.
  - A 1->0 transition only pulses out_chg.
- Latency, stable pad edge to lut_out: SYNC_STAGES + DEBOUNCE_CYCLES + 1 clk edges. Defaults give 7.
- Simultaneous channel changes: each channel debounces independently. Channels accepted on different edges can produce intermediate LUT values, each pulsing out_chg. No cross-channel qualification.
- Reset mid-debounce: partial counts are discarded. After release the filter restarts from the reset deb value.

Optional Feature:
- Macro: IO_LUT_FILTER_PULLUP_EN.
- Defined: sync flops and deb_out reset to all-ones, modelling PUDC-driven pull-ups during configuration.
  - lut_out resets to LUT_INIT[2^NUM_IN-1].
  - evt_cnt still resets to 0.
  - No event is counted for the reset value itself.
- Undefined: all reset values are 0 as above.

Decomposition:
- Package io_lut_filter_pkg holds:
  - a function for the debounce counter width;
  - a function producing the default AND truth table for a given NUM_IN;
  - localparam EVT_W_DEFAULT = 16;
  - a PULLUP_RESET constant bit set according to IO_LUT_FILTER_PULLUP_EN.
- One sub-module io_debounce_chan (parameters SYNC_STAGES, DEBOUNCE_CYCLES), instantiated NUM_IN times in a generate loop. The top holds the LUT register and the event counter.

Test Plan:
- Reset release, defaults, macro off -> deb_out=2'b00, lut_out=0, evt_cnt=0, out_chg=0. With the macro on -> deb_out=2'b11, lut_out=1, evt_cnt=0.
- pad_in 00->11 held -> lut_out rises exactly 7 edges later, out_chg pulses once, evt_cnt=1.
- pad_in[0] glitch high for 3 synchronised cycles (DEBOUNCE_CYCLES=4) -> deb_out never changes, out_chg never asserts.
- NUM_IN=3, LUT_INIT=8'h96 (XOR3), step pad_in through 000,001,011,111 with 20 cycles between -> lut_out sequence 0,1,0,1, evt_cnt=2.
- EVT_W=4, 20 full 0->1->0 pulse pairs on pad_in=11 -> evt_cnt holds 15 and evt_sat=1 from the 15th rise on.
- rst_n asserted 2 cycles into a debounce (pad_in 00->11) -> outputs clear immediately. After release with pad_in still 11, lut_out rises 7 edges later.
